// File: rtl/cross_bar_pkg.sv
`default_nettype none
// ============================================================================
// cross_bar_pkg : shared sizes and types for the crossbar master response path
// Revision      : 1.0
// ============================================================================
package cross_bar_pkg;

  localparam int SLAVE_N   = 4;
  localparam int DATA_W    = 32;
  localparam int OUT_DEPTH = 4;

  localparam int SIDX_W = (SLAVE_N > 1) ? $clog2(SLAVE_N) : 1;
  localparam int CNT_W  = $clog2(OUT_DEPTH + 1);

  typedef logic [DATA_W-1:0]  data_t;
  typedef logic [SLAVE_N-1:0] sgrant_t;
  typedef logic [SIDX_W-1:0]  sidx_t;
  typedef logic [CNT_W-1:0]   cnt_t;

endpackage
`default_nettype wire

// File: rtl/cross_bar_fifo.sv
`default_nettype none
// ============================================================================
// cross_bar_fifo : synchronous FIFO with combinational head (DEPTH power of 2)
// Revision       : 1.0
// ============================================================================
module cross_bar_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Pointers wrap on their own; count carries the extra bit to tell full from empty.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/cross_bar_master_resp.sv
`default_nettype none
// ============================================================================
// cross_bar_master_resp : in-order read response routing for one master
// Revision              : 1.0
// ============================================================================
module cross_bar_master_resp #(
  parameter int SLAVE_N   = cross_bar_pkg::SLAVE_N,
  parameter int DATA_W    = cross_bar_pkg::DATA_W,
  parameter int OUT_DEPTH = cross_bar_pkg::OUT_DEPTH
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           master_req,
  input  logic                           master_cmd,
  output logic                           master_ack,
  output logic                           master_resp,
  output logic [DATA_W-1:0]              master_rdata,
  output logic                           req_fwd,
  input  logic [SLAVE_N-1:0]             sgrant,
  input  logic [SLAVE_N-1:0]             slave_ack,
  input  logic [SLAVE_N-1:0]             slave_resp,
  input  logic [SLAVE_N*DATA_W-1:0]      slave_rdata,
  output logic [$clog2(OUT_DEPTH+1)-1:0] outstanding,
  output logic                           err_unexp
);

  localparam int IDX_W = (SLAVE_N > 1) ? $clog2(SLAVE_N) : 1;

  logic [IDX_W-1:0]   grant_idx;
  logic [IDX_W-1:0]   head;
  logic [SLAVE_N-1:0] head_oh;
  logic               full, empty;
  logic               accept, push;
  logic               err_d, err_q;

  // Lowest set grant bit wins when the grant is not one-hot.
  always_comb begin
    grant_idx = '0;
    for (int i = SLAVE_N - 1; i >= 0; i--) begin
      if (sgrant[i]) grant_idx = IDX_W'(i);
    end
  end

  assign req_fwd    = master_req && !full;
  assign master_ack = !full && |(sgrant & slave_ack);
  assign accept     = master_req && master_ack;
  assign push       = accept && !master_cmd;

  assign head_oh      = SLAVE_N'(1) << head;
  assign master_resp  = !empty && slave_resp[head];
  assign master_rdata = master_resp ? slave_rdata[head*DATA_W +: DATA_W] : '0;

  // Any response not from the head slave is dropped and flagged a cycle later.
  assign err_d = empty ? |slave_resp : |(slave_resp & ~head_oh);

  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign err_unexp = err_q;

  cross_bar_fifo #(
    .WIDTH (IDX_W),
    .DEPTH (OUT_DEPTH)
  ) u_order_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (master_resp),
    .wdata (grant_idx),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (outstanding)
  );

endmodule
`default_nettype wire

// File: tb/tb_cross_bar_master_resp.sv
`default_nettype none
// ============================================================================
// tb_cross_bar_master_resp : directed + random scoreboard bench
// Revision                 : 1.0
// ============================================================================
module tb_cross_bar_master_resp;

  localparam int SN = 4;
  localparam int DW = 32;
  localparam int OD = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          master_req = 1'b0;
  logic          master_cmd = 1'b0;
  logic          master_ack;
  logic          master_resp;
  logic [DW-1:0] master_rdata;
  logic          req_fwd;
  logic [SN-1:0] sgrant = '0;
  logic [SN-1:0] slave_ack = '0;
  logic [SN-1:0] slave_resp = '0;
  logic [SN*DW-1:0] slave_rdata;
  logic [2:0]    outstanding;
  logic          err_unexp;

  logic [DW-1:0] sd [SN];
  assign slave_rdata = {sd[3], sd[2], sd[1], sd[0]};

  always #5 clk = ~clk;

  cross_bar_master_resp #(.SLAVE_N(SN), .DATA_W(DW), .OUT_DEPTH(OD)) dut (
    .clk          (clk),
    .rst          (rst),
    .master_req   (master_req),
    .master_cmd   (master_cmd),
    .master_ack   (master_ack),
    .master_resp  (master_resp),
    .master_rdata (master_rdata),
    .req_fwd      (req_fwd),
    .sgrant       (sgrant),
    .slave_ack    (slave_ack),
    .slave_resp   (slave_resp),
    .slave_rdata  (slave_rdata),
    .outstanding  (outstanding),
    .err_unexp    (err_unexp)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: slave indices of pending reads in issue order.
  int            mq [$];
  logic [DW-1:0] exp_q [$];
  logic          pend_err = 1'b0;
  logic          exp_ack  = 1'b0;
  logic          exp_fwd  = 1'b0;
  logic          exp_resp = 1'b0;
  logic          chk_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic req, input logic cmd, input logic [3:0] g,
                      input logic [3:0] a, input logic [3:0] r,
                      input logic [31:0] d, input logic do_rst);
    logic       full;
    logic [3:0] stray;
    int         idx;
    @(posedge clk);
    #1;
    check("outstanding", 32'(outstanding), 32'(mq.size()));
    check("err_unexp", 32'(err_unexp), 32'(pend_err));
    master_req = req;
    master_cmd = cmd;
    sgrant     = g;
    slave_ack  = a;
    slave_resp = r;
    rst        = do_rst;
    for (int i = 0; i < SN; i++) sd[i] = (d != 0) ? d : $urandom();
    if (do_rst) begin
      mq.delete();
      exp_q.delete();
      pend_err = 1'b0;
      chk_en   = 1'b0;
    end else begin
      full     = (mq.size() == OD);
      exp_fwd  = req && !full;
      exp_ack  = !full && ((g & a) != 0);
      exp_resp = (mq.size() > 0) && r[mq[0]];
      if (mq.size() == 0) begin
        pend_err = (r != 0);
      end else begin
        stray        = r;
        stray[mq[0]] = 1'b0;
        pend_err     = (stray != 0);
      end
      if (exp_resp) begin
        exp_q.push_back(sd[mq[0]]);
        idx = mq.pop_front();
      end
      if (req && exp_ack && !cmd) begin
        idx = 0;
        for (int i = SN - 1; i >= 0; i--) if (g[i]) idx = i;
        mq.push_back(idx);
      end
      chk_en = 1'b1;
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 4'b0, 4'b0, 4'b0, 32'h0, 1'b0);
  endtask

  // Monitor: compares mid-cycle outputs and pops the scoreboard on each response.
  always @(negedge clk) begin
    if (chk_en) begin
      check("master_ack", 32'(master_ack), 32'(exp_ack));
      check("req_fwd", 32'(req_fwd), 32'(exp_fwd));
      check("master_resp", 32'(master_resp), 32'(exp_resp));
      if (master_resp) begin
        if (exp_q.size() == 0) begin
          check("resp_unexpected", 32'(master_resp), 32'h0);
        end else begin
          check("master_rdata", master_rdata, exp_q.pop_front());
        end
      end else begin
        check("rdata_zero", master_rdata, 32'h0);
      end
    end
  end

  initial begin
    logic       req, cmd, rs;
    logic [3:0] g, a, r;
    step(0, 0, 4'b0, 4'b0, 4'b0, 32'h0, 1'b1);
    step(0, 0, 4'b0, 4'b0, 4'b0, 32'h0, 1'b1);
    idle(2);

    // single read to slave 1
    step(1, 0, 4'b0010, 4'b0010, 4'b0, 32'h0, 0);
    idle(2);
    step(0, 0, 4'b0, 4'b0, 4'b0010, 32'hDEADBEEF, 0);
    idle(1);

    // ordering: reads 2,0,3; slave 0 answers early and is dropped
    step(1, 0, 4'b0100, 4'b0100, 4'b0, 32'h0, 0);
    step(1, 0, 4'b0001, 4'b0001, 4'b0, 32'h0, 0);
    step(1, 0, 4'b1000, 4'b1000, 4'b0, 32'h0, 0);
    step(0, 0, 4'b0, 4'b0, 4'b0001, 32'h11111111, 0);
    step(0, 0, 4'b0, 4'b0, 4'b0100, 32'h22222222, 0);
    step(0, 0, 4'b0, 4'b0, 4'b0001, 32'h33333333, 0);
    step(0, 0, 4'b0, 4'b0, 4'b1000, 32'h44444444, 0);
    idle(1);

    // full: four reads, then blocked, then one pop frees a slot
    for (int k = 0; k < 4; k++) step(1, 0, 4'b0010, 4'b0010, 4'b0, 32'h0, 0);
    step(1, 0, 4'b0010, 4'b0010, 4'b0, 32'h0, 0);
    step(1, 0, 4'b0010, 4'b0010, 4'b0010, 32'h55555555, 0);
    step(1, 0, 4'b0010, 4'b0010, 4'b0, 32'h0, 0);
    for (int k = 0; k < 4; k++) step(0, 0, 4'b0, 4'b0, 4'b0010, 32'h60000000 + k, 0);
    idle(1);

    // simultaneous push and pop
    step(1, 0, 4'b0001, 4'b0001, 4'b0, 32'h0, 0);
    step(1, 0, 4'b0100, 4'b0100, 4'b0, 32'h0, 0);
    step(1, 0, 4'b1000, 4'b1000, 4'b0001, 32'h66666666, 0);
    step(0, 0, 4'b0, 4'b0, 4'b0100, 32'h77777777, 0);
    step(0, 0, 4'b0, 4'b0, 4'b1000, 32'h88888888, 0);
    idle(1);

    // writes are not queued; stray response flagged
    for (int k = 0; k < 3; k++) step(1, 1, 4'b0001, 4'b0001, 4'b0, 32'h0, 0);
    step(0, 0, 4'b0, 4'b0, 4'b0001, 32'h99999999, 0);
    idle(2);

    // reset with two reads queued; late response becomes unexpected
    step(1, 0, 4'b0001, 4'b0001, 4'b0, 32'h0, 0);
    step(1, 0, 4'b0010, 4'b0010, 4'b0, 32'h0, 0);
    step(0, 0, 4'b0, 4'b0, 4'b0, 32'h0, 1);
    step(0, 0, 4'b0, 4'b0, 4'b0001, 32'hAAAAAAAA, 0);
    idle(2);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      req = ($urandom_range(0, 3) != 0);
      cmd = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 9))
        0:       g = 4'b0;
        1:       g = 4'($urandom());
        default: g = 4'(1 << $urandom_range(0, 3));
      endcase
      a = 4'($urandom()) | (($urandom_range(0, 1) != 0) ? g : 4'b0);
      if (mq.size() > 0 && $urandom_range(0, 2) == 0) r = 4'(1 << mq[0]);
      else if ($urandom_range(0, 19) == 0)          r = 4'($urandom());
      else                                          r = 4'b0;
      rs = ($urandom_range(0, 499) == 0);
      step(req, cmd, g, a, r, 32'h0, rs);
    end

    // drain anything left
    for (int k = 0; k < OD + 1; k++) begin
      if (mq.size() > 0) step(0, 0, 4'b0, 4'b0, 4'(1 << mq[0]), 32'h0, 0);
      else               idle(1);
    end
    idle(2);
    check("scoreboard_empty", 32'(exp_q.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
